// File: rtl/spi_target_pkg.sv
// +------------------------------------------------------------------+
// | spi_target_pkg : register map and bit indices for spi_target     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package spi_target_pkg;

  localparam logic [2:0] SPIT_DATA   = 3'd0;
  localparam logic [2:0] SPIT_STATUS = 3'd1;
  localparam logic [2:0] SPIT_CTRL   = 3'd2;
  localparam logic [2:0] SPIT_IRQ    = 3'd3;

  // status read bit positions
  localparam int ST_RX_FULL   = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_UNDERRUN  = 3;
  localparam int ST_CS_ACTIVE = 4;

  // status write bits that clear the sticky error flags
  localparam int CLR_OVERRUN  = 3;
  localparam int CLR_UNDERRUN = 4;

  localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

  typedef struct packed {
    logic cs_end_ie;
    logic tx_empty_ie;
    logic rx_ie;
    logic cpol;
    logic cpha;
  } ctrl_t;

  typedef struct packed {
    logic cs_end;
    logic tx_empty;
    logic rx_done;
  } irq_t;

endpackage

`default_nettype wire

// File: rtl/spi_target_if.sv
// +------------------------------------------------------------------+
// | spi_target_if : 8-bit peripheral register bus plus interrupt     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface spi_target_if;
  logic [2:0] reg_addr;
  logic [7:0] reg_data_in;
  logic [7:0] reg_data_out;
  logic       reg_read;
  logic       reg_write;
  logic       interrupt;

  modport master (
    output reg_addr, reg_data_in, reg_read, reg_write,
    input  reg_data_out, interrupt
  );

  modport slave (
    input  reg_addr, reg_data_in, reg_read, reg_write,
    output reg_data_out, interrupt
  );
endinterface

`default_nettype wire

// File: rtl/spi_target_sync2.sv
// +------------------------------------------------------------------+
// | sync2 : two-flop synchroniser with selectable reset value        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= rst_val;
      sync_q <= rst_val;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/spi_target.sv
// +------------------------------------------------------------------+
// | spi_target : SPI target, byte shifter in all four modes with     |
// |              RX/TX holding registers, status and interrupt. 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module spi_target
  import spi_target_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sclk,
  input  logic         mosi,
  input  logic         cs_n,
  output logic         miso,
  output logic         miso_oe,
  spi_target_if.slave  bus
);

  logic sclk_s, mosi_s, cs_n_s;

  sync2 u_sync_sclk (.clk(clk), .rst_n(reset_n), .rst_val(1'b0), .d(sclk), .q(sclk_s));
  sync2 u_sync_cs_n (.clk(clk), .rst_n(reset_n), .rst_val(1'b1), .d(cs_n), .q(cs_n_s));
  sync2 u_sync_mosi (.clk(clk), .rst_n(reset_n), .rst_val(1'b0), .d(mosi), .q(mosi_s));

  logic       sclk_prev_q, sclk_prev_d;
  logic       cs_n_prev_q, cs_n_prev_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       load_pending_q, load_pending_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       rx_full_q, rx_full_d;
  logic       tx_full_q, tx_full_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  ctrl_t      ctrl_q, ctrl_d;
  irq_t       irq_q, irq_d;
  logic       interrupt_q, interrupt_d;

  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       cs_active, cs_fall, cs_rise;
  logic       sample_edge, shift_edge, do_load;
  logic       wr_data, rd_data, wr_status, wr_ctrl, wr_irq;
  logic [7:0] rx_byte;
  irq_t       irq_en;
  logic [7:0] rdata;

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = ctrl_q.cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = ctrl_q.cpol ? sclk_rise : sclk_fall;
  assign cs_active   = ~cs_n_s;
  assign cs_fall     = cs_n_prev_q & ~cs_n_s;
  assign cs_rise     = ~cs_n_prev_q & cs_n_s;
  assign sample_edge = cs_active & (ctrl_q.cpha ? trail_edge : lead_edge);
  assign shift_edge  = cs_active & (ctrl_q.cpha ? lead_edge : trail_edge);
  assign do_load     = (cs_fall & ~ctrl_q.cpha) | (shift_edge & load_pending_q);
  assign rx_byte     = {rx_sr_q[6:0], mosi_s};
  assign irq_en      = {ctrl_q.cs_end_ie, ctrl_q.tx_empty_ie, ctrl_q.rx_ie};

  assign wr_data   = bus.reg_write && (bus.reg_addr == SPIT_DATA);
  assign rd_data   = bus.reg_read  && (bus.reg_addr == SPIT_DATA);
  assign wr_status = bus.reg_write && (bus.reg_addr == SPIT_STATUS);
  assign wr_ctrl   = bus.reg_write && (bus.reg_addr == SPIT_CTRL);
  assign wr_irq    = bus.reg_write && (bus.reg_addr == SPIT_IRQ);

  // Software clears are applied first so that any hardware set in the
  // same cycle overrides them.
  always_comb begin
    sclk_prev_d    = sclk_s;
    cs_n_prev_d    = cs_n_s;
    tx_sr_d        = tx_sr_q;
    rx_sr_d        = rx_sr_q;
    bit_cnt_d      = bit_cnt_q;
    load_pending_d = load_pending_q;
    rx_data_d      = rx_data_q;
    tx_hold_d      = tx_hold_q;
    rx_full_d      = rx_full_q;
    tx_full_d      = tx_full_q;
    overrun_d      = overrun_q;
    underrun_d     = underrun_q;
    ctrl_d         = ctrl_q;
    irq_d          = irq_q;
    interrupt_d    = |(irq_q & irq_en);

    if (wr_data) tx_hold_d = bus.reg_data_in;
    if (rd_data) rx_full_d = 1'b0;
    if (wr_status) begin
      if (bus.reg_data_in[CLR_OVERRUN])  overrun_d  = 1'b0;
      if (bus.reg_data_in[CLR_UNDERRUN]) underrun_d = 1'b0;
    end
    if (wr_ctrl) ctrl_d = ctrl_t'(bus.reg_data_in[4:0]);
    if (wr_irq)  irq_d  = irq_q & ~irq_t'(bus.reg_data_in[2:0]);

    if (cs_fall) begin
      bit_cnt_d = 3'd0;
      if (ctrl_q.cpha) load_pending_d = 1'b1;
    end

    // A load reads the old holding value; a same-cycle write refills it below.
    if (do_load) begin
      load_pending_d = 1'b0;
      if (tx_full_q) begin
        tx_sr_d        = tx_hold_q;
        tx_full_d      = 1'b0;
        irq_d.tx_empty = 1'b1;
      end else begin
        tx_sr_d    = TX_IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end else if (shift_edge) begin
      tx_sr_d = {tx_sr_q[6:0], 1'b1};
    end

    if (wr_data) tx_full_d = 1'b1;

    if (sample_edge) begin
      rx_sr_d = rx_byte;
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d      = 3'd0;
        load_pending_d = 1'b1;
        if (!rx_full_q) begin
          rx_data_d     = rx_byte;
          rx_full_d     = 1'b1;
          irq_d.rx_done = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end

    if (cs_rise) begin
      bit_cnt_d      = 3'd0;
      load_pending_d = 1'b0;
      irq_d.cs_end   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q    <= 1'b0;
      cs_n_prev_q    <= 1'b1;
      tx_sr_q        <= TX_IDLE_BYTE;
      rx_sr_q        <= 8'h00;
      bit_cnt_q      <= 3'd0;
      load_pending_q <= 1'b0;
      rx_data_q      <= 8'h00;
      tx_hold_q      <= 8'h00;
      rx_full_q      <= 1'b0;
      tx_full_q      <= 1'b0;
      overrun_q      <= 1'b0;
      underrun_q     <= 1'b0;
      ctrl_q         <= '0;
      irq_q          <= '0;
      interrupt_q    <= 1'b0;
    end else begin
      sclk_prev_q    <= sclk_prev_d;
      cs_n_prev_q    <= cs_n_prev_d;
      tx_sr_q        <= tx_sr_d;
      rx_sr_q        <= rx_sr_d;
      bit_cnt_q      <= bit_cnt_d;
      load_pending_q <= load_pending_d;
      rx_data_q      <= rx_data_d;
      tx_hold_q      <= tx_hold_d;
      rx_full_q      <= rx_full_d;
      tx_full_q      <= tx_full_d;
      overrun_q      <= overrun_d;
      underrun_q     <= underrun_d;
      ctrl_q         <= ctrl_d;
      irq_q          <= irq_d;
      interrupt_q    <= interrupt_d;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (bus.reg_addr)
      SPIT_DATA: rdata = rx_data_q;
      SPIT_STATUS: begin
        rdata[ST_RX_FULL]   = rx_full_q;
        rdata[ST_TX_FULL]   = tx_full_q;
        rdata[ST_OVERRUN]   = overrun_q;
        rdata[ST_UNDERRUN]  = underrun_q;
        rdata[ST_CS_ACTIVE] = cs_active;
      end
      SPIT_CTRL: rdata = {3'b000, ctrl_q};
      SPIT_IRQ:  rdata = {5'b00000, irq_q};
      default:   rdata = 8'h00;
    endcase
  end

  assign bus.reg_data_out = rdata;
  assign bus.interrupt    = interrupt_q;
  assign miso             = tx_sr_q[7];
  assign miso_oe          = cs_active;

endmodule

`default_nettype wire

// File: tb/tb_spi_target.sv
// +------------------------------------------------------------------+
// | tb_spi_target : self-checking bench for spi_target               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_spi_target;
  import spi_target_pkg::*;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
  logic miso, miso_oe;

  spi_target_if bus_if ();

  spi_target dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .miso    (miso),
    .miso_oe (miso_oe),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_miso_q[$];

  typedef struct {
    logic [1:0] mode;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_status;
    logic [7:0] exp_irq;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.reg_addr    = a;
    bus_if.reg_data_in = d;
    bus_if.reg_write   = 1'b1;
    @(negedge clk);
    bus_if.reg_write   = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_if.reg_addr = a;
    bus_if.reg_read = 1'b1;
    #1 d = bus_if.reg_data_out;
    @(negedge clk);
    bus_if.reg_read = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    reg_rd(a, v);
    check(name, v, exp);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, input logic cpol,
                          input logic cpha, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        clks(HALF);
        mi   = {mi[6:0], miso};
        sclk = ~cpol;
        clks(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[i];
        clks(HALF);
        mi   = {mi[6:0], miso};
        sclk = cpol;
        clks(HALF);
      end
    end
    if (!cpha) clks(HALF);
  endtask

  task automatic spi_byte(input logic [7:0] mo, input logic cpol, input logic cpha,
                          input string name);
    logic [7:0] mi;
    spi_bits(mo, 8, cpol, cpha, mi);
    if (exp_miso_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %02h expected none (scoreboard empty)", name, mi);
    end else begin
      check(name, mi, exp_miso_q.pop_front());
    end
  endtask

  task automatic cs_assert();
    cs_n = 1'b0;
    clks(8);
  endtask

  task automatic cs_release();
    cs_n = 1'b1;
    clks(8);
  endtask

  task automatic set_mode(input logic [1:0] mode, input logic [7:0] extra);
    reg_wr(SPIT_CTRL, extra | {6'b0, mode});
    sclk = mode[1];
    clks(8);
  endtask

  task automatic clear_flags();
    reg_wr(SPIT_IRQ, 8'h07);
    reg_wr(SPIT_STATUS, 8'h18);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mi;
    bus_if.reg_addr    = 3'd0;
    bus_if.reg_data_in = 8'h00;
    bus_if.reg_read    = 1'b0;
    bus_if.reg_write   = 1'b0;

    // cpha=0 modes take one extra load after the last bit, so an unrefilled
    // holding register leaves underrun set once the byte is over.
    vecs[0] = '{mode: 2'd0, tx: 8'hA5, mo: 8'h3C, exp_status: 8'h08, exp_irq: 8'h07};
    vecs[1] = '{mode: 2'd1, tx: 8'h5A, mo: 8'hC3, exp_status: 8'h00, exp_irq: 8'h07};
    vecs[2] = '{mode: 2'd2, tx: 8'h0F, mo: 8'hF0, exp_status: 8'h08, exp_irq: 8'h07};
    vecs[3] = '{mode: 2'd3, tx: 8'h81, mo: 8'h7E, exp_status: 8'h00, exp_irq: 8'h07};

    clks(3);
    check("reset miso", {7'b0, miso}, 8'h01);
    check("reset miso_oe", {7'b0, miso_oe}, 8'h00);
    check("reset interrupt", {7'b0, bus_if.interrupt}, 8'h00);
    reset_n = 1'b1;
    clks(2);
    rd_check("reset status", SPIT_STATUS, 8'h00);
    rd_check("reset ctrl", SPIT_CTRL, 8'h00);
    rd_check("reset irq", SPIT_IRQ, 8'h00);
    rd_check("reset data", SPIT_DATA, 8'h00);

    for (int k = 0; k < 4; k++) begin
      set_mode(vecs[k].mode, 8'h04);
      reg_wr(SPIT_DATA, vecs[k].tx);
      exp_miso_q.push_back(vecs[k].tx);
      cs_assert();
      check($sformatf("vec%0d miso_oe", k), {7'b0, miso_oe}, 8'h01);
      spi_byte(vecs[k].mo, vecs[k].mode[1], vecs[k].mode[0], $sformatf("vec%0d miso byte", k));
      cs_release();
      check($sformatf("vec%0d interrupt", k), {7'b0, bus_if.interrupt}, 8'h01);
      rd_check($sformatf("vec%0d irq", k), SPIT_IRQ, vecs[k].exp_irq);
      rd_check($sformatf("vec%0d rx", k), SPIT_DATA, vecs[k].mo);
      rd_check($sformatf("vec%0d status", k), SPIT_STATUS, vecs[k].exp_status);
      clear_flags();
      clks(2);
      check($sformatf("vec%0d interrupt cleared", k), {7'b0, bus_if.interrupt}, 8'h00);
    end

    // mode 3, two bytes back to back with refill on tx-empty
    set_mode(2'd3, 8'h08);
    reg_wr(SPIT_DATA, 8'h11);
    exp_miso_q.push_back(8'h11);
    cs_assert();
    spi_byte(8'h81, 1'b1, 1'b1, "b2b byte0 miso");
    clks(2);
    check("b2b tx_empty interrupt", {7'b0, bus_if.interrupt}, 8'h01);
    reg_wr(SPIT_DATA, 8'h22);
    reg_wr(SPIT_IRQ, 8'h07);
    rd_check("b2b rx0", SPIT_DATA, 8'h81);
    exp_miso_q.push_back(8'h22);
    spi_byte(8'h7E, 1'b1, 1'b1, "b2b byte1 miso");
    cs_release();
    rd_check("b2b rx1", SPIT_DATA, 8'h7E);
    rd_check("b2b status", SPIT_STATUS, 8'h00);
    clear_flags();

    // overrun: two bytes, no read in between, no TX data either
    set_mode(2'd0, 8'h00);
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
    cs_assert();
    spi_byte(8'h96, 1'b0, 1'b0, "ovr byte0 miso");
    spi_byte(8'h69, 1'b0, 1'b0, "ovr byte1 miso");
    cs_release();
    rd_check("ovr status", SPIT_STATUS, 8'h0D);
    rd_check("ovr rx keeps first", SPIT_DATA, 8'h96);
    reg_wr(SPIT_STATUS, 8'h08);
    rd_check("ovr cleared", SPIT_STATUS, 8'h08);
    reg_wr(SPIT_STATUS, 8'h10);
    rd_check("udr cleared", SPIT_STATUS, 8'h00);
    clear_flags();

    // underrun in mode 1
    set_mode(2'd1, 8'h00);
    exp_miso_q.push_back(8'hFF);
    cs_assert();
    spi_byte(8'h00, 1'b0, 1'b1, "udr miso");
    cs_release();
    rd_check("udr status", SPIT_STATUS, 8'h09);
    rd_check("udr rx", SPIT_DATA, 8'h00);
    clear_flags();

    // holding overwrite while full: last write wins, no error
    reg_wr(SPIT_DATA, 8'h12);
    reg_wr(SPIT_DATA, 8'h34);
    rd_check("overwrite tx_full", SPIT_STATUS, 8'h02);
    exp_miso_q.push_back(8'h34);
    cs_assert();
    spi_byte(8'hE1, 1'b0, 1'b1, "overwrite miso");
    cs_release();
    rd_check("overwrite rx", SPIT_DATA, 8'hE1);
    rd_check("overwrite status", SPIT_STATUS, 8'h00);
    clear_flags();

    // abort after 5 bits, then a full byte
    set_mode(2'd0, 8'h00);
    reg_wr(SPIT_DATA, 8'hE7);
    cs_assert();
    spi_bits(8'hA0, 5, 1'b0, 1'b0, mi);
    check("abort partial miso", mi, 8'h1C);
    cs_release();
    rd_check("abort status", SPIT_STATUS, 8'h00);
    rd_check("abort irq", SPIT_IRQ, 8'h06);
    clear_flags();
    reg_wr(SPIT_DATA, 8'h3C);
    exp_miso_q.push_back(8'h3C);
    cs_assert();
    spi_byte(8'hC3, 1'b0, 1'b0, "post-abort miso");
    cs_release();
    rd_check("post-abort rx", SPIT_DATA, 8'hC3);
    clear_flags();

    // async reset three bits into a byte
    set_mode(2'd0, 8'h04);
    reg_wr(SPIT_DATA, 8'hB4);
    cs_assert();
    spi_bits(8'h55, 3, 1'b0, 1'b0, mi);
    reset_n = 1'b0;
    #1;
    check("rst mid miso_oe", {7'b0, miso_oe}, 8'h00);
    check("rst mid miso", {7'b0, miso}, 8'h01);
    check("rst mid interrupt", {7'b0, bus_if.interrupt}, 8'h00);
    cs_n = 1'b1;
    sclk = 1'b0;
    clks(3);
    reset_n = 1'b1;
    clks(2);
    rd_check("rst mid status", SPIT_STATUS, 8'h00);
    rd_check("rst mid ctrl", SPIT_CTRL, 8'h00);
    rd_check("rst mid irq", SPIT_IRQ, 8'h00);
    set_mode(2'd2, 8'h00);
    reg_wr(SPIT_DATA, 8'h99);
    exp_miso_q.push_back(8'h99);
    cs_assert();
    spi_byte(8'h5A, 1'b1, 1'b0, "post-rst miso");
    cs_release();
    rd_check("post-rst rx", SPIT_DATA, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
